// File: rtl/vid_capture.sv
// Receive-side checker for the RGB444 + HS/VS/DE pixel bus: measures frame geometry,
// computes a per-frame CRC-16 over active pixels and tracks timing lock.
module vid_capture #(
    parameter int CNT_W       = 12,
    parameter int LOCK_FRAMES = 2
) (
    input  logic             pixclk,
    input  logic             resetn,
    input  logic [3:0]       vid_r,
    input  logic [3:0]       vid_g,
    input  logic [3:0]       vid_b,
    input  logic             vid_hs,
    input  logic             vid_vs,
    input  logic             vid_de,
    input  logic             clr_err,
    output logic [CNT_W-1:0] h_active,
    output logic [CNT_W-1:0] v_active,
    output logic [CNT_W-1:0] h_total,
    output logic [CNT_W-1:0] v_total,
    output logic [15:0]      frame_crc,
    output logic             crc_valid,
    output logic [15:0]      frame_cnt,
    output logic             locked,
    output logic             err_timing,
    output logic             err_line
);

    localparam int MCW = $clog2(LOCK_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

    function automatic logic [15:0] crc_step(input logic [15:0] crc_in, input logic [11:0] data);
        logic [15:0] c;
        c = crc_in;
        for (int i = 11; i >= 0; i--) begin
            if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else                 c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    logic [11:0]      rgb_reg;
    logic             de_reg, hs_reg, vs_reg, hs_d_reg, vs_d_reg, clr_reg;
    logic             hs_rise, vs_rise;
    logic [CNT_W-1:0] pix_reg, pix_next, cyc_reg, cyc_next, h_tot_reg, h_tot_next;
    logic [CNT_W-1:0] v_cnt_reg, v_cnt_next, hs_cnt_reg, hs_cnt_next, first_h_reg, first_h_next;
    logic             have_first_reg, have_first_next, sat_reg, sat_next, line_err;
    logic [15:0]      crc_reg, crc_fold, crc_snap_reg;
    logic             seen_vs_reg, clr_pend_reg, latch_pend_reg;
    state_t           state_reg, state_next;
    logic [MCW-1:0]   match_cnt_reg, match_cnt_next;
    logic             match, timing_evt;

    // Edges come from the first register stage against the second.
    always_ff @(posedge pixclk) begin
        if (!resetn) begin
            rgb_reg  <= '0;
            de_reg   <= 1'b0;
            hs_reg   <= 1'b0;
            vs_reg   <= 1'b0;
            hs_d_reg <= 1'b0;
            vs_d_reg <= 1'b0;
            clr_reg  <= 1'b0;
        end else begin
            rgb_reg  <= {vid_r, vid_g, vid_b};
            de_reg   <= vid_de;
            hs_reg   <= vid_hs;
            vs_reg   <= vid_vs;
            hs_d_reg <= hs_reg;
            vs_d_reg <= vs_reg;
            clr_reg  <= clr_err;
        end
    end

    assign hs_rise  = hs_reg & ~hs_d_reg;
    assign vs_rise  = vs_reg & ~vs_d_reg;
    assign crc_fold = de_reg ? crc_step(crc_reg, rgb_reg) : crc_reg;

    // Frame counters clear the cycle after a VS rise; an HS rise landing there starts from zero.
    always_comb begin
        v_cnt_next      = clr_pend_reg ? '0 : v_cnt_reg;
        hs_cnt_next     = clr_pend_reg ? '0 : hs_cnt_reg;
        first_h_next    = clr_pend_reg ? '0 : first_h_reg;
        have_first_next = clr_pend_reg ? 1'b0 : have_first_reg;
        sat_next        = clr_pend_reg ? 1'b0 : sat_reg;
        h_tot_next      = h_tot_reg;
        pix_next        = pix_reg;
        cyc_next        = cyc_reg;
        line_err        = 1'b0;
        if (cyc_reg == CNT_MAX) sat_next = 1'b1;
        else                    cyc_next = cyc_reg + 1'b1;
        if (de_reg) begin
            if (pix_reg == CNT_MAX) sat_next = 1'b1;
            else                    pix_next = pix_reg + 1'b1;
        end
        if (hs_rise) begin
            h_tot_next = cyc_reg;
            cyc_next   = {{(CNT_W-1){1'b0}}, 1'b1};
            pix_next   = {{(CNT_W-1){1'b0}}, de_reg};
            if (hs_cnt_next == CNT_MAX) sat_next = 1'b1;
            else                        hs_cnt_next = hs_cnt_next + 1'b1;
            if (pix_reg != '0) begin
                if (v_cnt_next == CNT_MAX) sat_next = 1'b1;
                else                       v_cnt_next = v_cnt_next + 1'b1;
                if (!have_first_next) begin
                    first_h_next    = pix_reg;
                    have_first_next = 1'b1;
                end else if (pix_reg != first_h_next) begin
                    line_err = 1'b1;
                end
            end
        end
    end

    assign match = (first_h_reg == h_active) && (v_cnt_reg == v_active) &&
                   (h_tot_reg == h_total) && (hs_cnt_reg == v_total) && !sat_reg;

    always_comb begin
        state_next     = state_reg;
        match_cnt_next = match_cnt_reg;
        timing_evt     = 1'b0;
        if (latch_pend_reg) begin
            case (state_reg)
                IDLE: begin
                    state_next     = MEASURE;
                    match_cnt_next = '0;
                end
                MEASURE: begin
                    if (match) begin
                        match_cnt_next = match_cnt_reg + 1'b1;
                        if (int'(match_cnt_reg) + 1 >= LOCK_FRAMES) state_next = LOCKED;
                    end else begin
                        match_cnt_next = '0;
                    end
                end
                LOCKED: begin
                    if (!match) begin
                        timing_evt     = 1'b1;
                        state_next     = MEASURE;
                        match_cnt_next = '0;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign locked = (state_reg == LOCKED);

    always_ff @(posedge pixclk) begin
        if (!resetn) begin
            pix_reg        <= '0;
            cyc_reg        <= '0;
            h_tot_reg      <= '0;
            v_cnt_reg      <= '0;
            hs_cnt_reg     <= '0;
            first_h_reg    <= '0;
            have_first_reg <= 1'b0;
            sat_reg        <= 1'b0;
            crc_reg        <= '0;
            crc_snap_reg   <= '0;
            seen_vs_reg    <= 1'b0;
            clr_pend_reg   <= 1'b0;
            latch_pend_reg <= 1'b0;
            state_reg      <= IDLE;
            match_cnt_reg  <= '0;
            h_active       <= '0;
            v_active       <= '0;
            h_total        <= '0;
            v_total        <= '0;
            frame_crc      <= '0;
            crc_valid      <= 1'b0;
            frame_cnt      <= '0;
            err_timing     <= 1'b0;
            err_line       <= 1'b0;
        end else begin
            pix_reg        <= pix_next;
            cyc_reg        <= cyc_next;
            h_tot_reg      <= h_tot_next;
            v_cnt_reg      <= v_cnt_next;
            hs_cnt_reg     <= hs_cnt_next;
            first_h_reg    <= first_h_next;
            have_first_reg <= have_first_next;
            sat_reg        <= sat_next;
            if (vs_rise) begin
                crc_snap_reg <= crc_fold;
                crc_reg      <= 16'hFFFF;
            end else begin
                crc_reg      <= crc_fold;
            end
            seen_vs_reg    <= seen_vs_reg | vs_rise;
            clr_pend_reg   <= vs_rise;
            latch_pend_reg <= vs_rise & seen_vs_reg;
            state_reg      <= state_next;
            match_cnt_reg  <= match_cnt_next;
            crc_valid      <= latch_pend_reg;
            if (latch_pend_reg) begin
                h_active  <= first_h_reg;
                v_active  <= v_cnt_reg;
                h_total   <= h_tot_reg;
                v_total   <= hs_cnt_reg;
                frame_crc <= crc_snap_reg;
                frame_cnt <= frame_cnt + 1'b1;
            end
            // A new error event outranks a simultaneous clear.
            err_line   <= line_err | (err_line & ~clr_reg);
            err_timing <= timing_evt | (err_timing & ~clr_reg);
        end
    end

endmodule

// File: tb/tb_vid_capture.sv
// Self-checking bench for vid_capture: frames are described at a high level, the expected
// per-frame results are computed from the description and compared on every cycle.
module tb_vid_capture;
    localparam int CNT_W = 12;
    localparam int LOCK_FRAMES = 2;

    logic pixclk = 1'b0;
    logic resetn = 1'b0;
    logic [3:0] vid_r = '0, vid_g = '0, vid_b = '0;
    logic vid_hs = 1'b0, vid_vs = 1'b0, vid_de = 1'b0, clr_err = 1'b0;
    logic [CNT_W-1:0] h_active, v_active, h_total, v_total;
    logic [15:0] frame_crc, frame_cnt;
    logic crc_valid, locked, err_timing, err_line;

    vid_capture #(.CNT_W(CNT_W), .LOCK_FRAMES(LOCK_FRAMES)) dut (
        .pixclk(pixclk), .resetn(resetn), .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b),
        .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_de(vid_de), .clr_err(clr_err),
        .h_active(h_active), .v_active(v_active), .h_total(h_total), .v_total(v_total),
        .frame_crc(frame_crc), .crc_valid(crc_valid), .frame_cnt(frame_cnt),
        .locked(locked), .err_timing(err_timing), .err_line(err_line)
    );

    always #5 pixclk = ~pixclk;

    typedef struct {
        int h_act; int v_act; int h_tot; int v_tot;
        logic [15:0] crc; int fcnt; bit lck; bit err_t; bit err_l;
    } exp_t;

    typedef struct {
        int h_act; int v_act; int h_tot; int v_tot; int vs_off;
        int pat; int seed; int alt; int short_line; int clr; int rst_line;
    } fr_t;

    exp_t exp_q[$];
    exp_t cur;
    int errors = 0, checks = 0, pushed = 0, pulses = 0;
    int m_fcnt = 0, m_cnt = 0;
    bit m_started = 0, m_locked = 0, m_err_t = 0, m_err_l = 0;
    int prev_h = 0, prev_v = 0, prev_ht = 0, prev_vt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] crc12(input logic [15:0] c_in, input logic [11:0] d);
        logic [15:0] c;
        logic fb;
        c = c_in;
        for (int i = 11; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    function automatic logic [11:0] pix_val(input fr_t f, input int x, input int y);
        logic [11:0] v;
        case (f.pat)
            0: v = 12'h000;
            1: v = 12'((x << 8) ^ (y << 4) ^ (x + y));
            default: v = 12'((x * 37) + (y * 101) + (f.seed * 13)) ^ 12'(f.seed >> 4);
        endcase
        if (f.alt != 0 && x == 3 && y == 2) v = v ^ 12'h001;
        return v;
    endfunction

    function automatic fr_t mk(input int ha, input int va, input int ht, input int vt,
                               input int vo, input int pat, input int seed);
        fr_t f;
        f.h_act = ha; f.v_act = va; f.h_tot = ht; f.v_tot = vt; f.vs_off = vo;
        f.pat = pat; f.seed = seed; f.alt = 0; f.short_line = -1; f.clr = 0; f.rst_line = -1;
        return f;
    endfunction

    function automatic int line_len(input fr_t f, input int y);
        return (y == f.short_line) ? f.h_act - 1 : f.h_act;
    endfunction

    // Expected result of the latch that closes frame f, derived from the frame description.
    task automatic model_push(input fr_t f);
        exp_t e;
        bit match;
        logic [15:0] c;
        c = 16'hFFFF;
        for (int y = 0; y < f.v_act; y++)
            for (int x = 0; x < line_len(f, y); x++)
                c = crc12(c, pix_val(f, x, y));
        if (f.clr != 0) begin m_err_t = 0; m_err_l = 0; end
        if (f.short_line >= 0) m_err_l = 1;
        match = (f.h_act == prev_h) && (f.v_act == prev_v) && (f.h_tot == prev_ht) && (f.v_tot == prev_vt);
        if (!m_started) begin
            m_started = 1; m_locked = 0; m_cnt = 0;
        end else if (!m_locked) begin
            if (match) begin
                m_cnt++;
                if (m_cnt >= LOCK_FRAMES) m_locked = 1;
            end else m_cnt = 0;
        end else if (!match) begin
            m_err_t = 1; m_locked = 0; m_cnt = 0;
        end
        prev_h = f.h_act; prev_v = f.v_act; prev_ht = f.h_tot; prev_vt = f.v_tot;
        m_fcnt = (m_fcnt + 1) & 16'hFFFF;
        e.h_act = f.h_act; e.v_act = f.v_act; e.h_tot = f.h_tot; e.v_tot = f.v_tot;
        e.crc = c; e.fcnt = m_fcnt; e.lck = m_locked; e.err_t = m_err_t; e.err_l = m_err_l;
        exp_q.push_back(e);
        pushed++;
    endtask

    task automatic model_reset();
        m_fcnt = 0; m_cnt = 0; m_started = 0; m_locked = 0; m_err_t = 0; m_err_l = 0;
        prev_h = 0; prev_v = 0; prev_ht = 0; prev_vt = 0;
        cur = '{default: 0};
    endtask

    task automatic pins_idle();
        vid_hs = 0; vid_vs = 0; vid_de = 0; clr_err = 0;
        {vid_r, vid_g, vid_b} = 12'h000;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_h_active"}, 32'(h_active), 0);
        check({tag, "_v_active"}, 32'(v_active), 0);
        check({tag, "_h_total"}, 32'(h_total), 0);
        check({tag, "_v_total"}, 32'(v_total), 0);
        check({tag, "_frame_crc"}, 32'(frame_crc), 0);
        check({tag, "_frame_cnt"}, 32'(frame_cnt), 0);
        check({tag, "_crc_valid"}, 32'(crc_valid), 0);
        check({tag, "_locked"}, 32'(locked), 0);
        check({tag, "_err_timing"}, 32'(err_timing), 0);
        check({tag, "_err_line"}, 32'(err_line), 0);
    endtask

    task automatic run_frame(input fr_t f);
        int n;
        if (f.rst_line < 0) model_push(f);
        for (int y = 0; y < f.v_tot; y++) begin
            for (int c = 0; c < f.h_tot; c++) begin
                if (y == f.rst_line && c == 5) begin
                    resetn = 0;
                    pins_idle();
                    @(posedge pixclk); #1;
                    model_reset();
                    check("queue_empty_at_reset", 32'(exp_q.size()), 0);
                    repeat (2) begin @(posedge pixclk); #1; end
                    check_all_zero("midreset");
                    resetn = 1;
                    repeat (10) begin @(posedge pixclk); #1; end
                    return;
                end
                n = line_len(f, y);
                vid_hs = (c < 2);
                vid_vs = (y == 0 && c >= f.vs_off) || (y == 1 && c < f.vs_off);
                vid_de = (y < f.v_act) && (c >= 4) && (c < 4 + n);
                if (vid_de) {vid_r, vid_g, vid_b} = pix_val(f, c - 4, y);
                else        {vid_r, vid_g, vid_b} = 12'($urandom);
                clr_err = (f.clr != 0) && (y == 1) && (c == 10);
                @(posedge pixclk); #1;
            end
        end
        pins_idle();
    endtask

    // Closing VS with its coincident HS, so the last frame is latched.
    task automatic run_tail();
        for (int c = 0; c < 12; c++) begin
            vid_hs = (c < 2); vid_vs = 1; vid_de = 0;
            @(posedge pixclk); #1;
        end
        pins_idle();
        repeat (20) begin @(posedge pixclk); #1; end
    endtask

    always @(negedge pixclk) begin
        if (resetn) begin
            if (crc_valid) begin
                pulses++;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_crc_valid: got 1 expected 0 at %0t", $time);
                end else begin
                    cur = exp_q.pop_front();
                    check("locked_at_latch", 32'(locked), 32'(cur.lck));
                    check("err_timing_at_latch", 32'(err_timing), 32'(cur.err_t));
                    check("err_line_at_latch", 32'(err_line), 32'(cur.err_l));
                end
            end
            check("h_active", 32'(h_active), 32'(cur.h_act));
            check("v_active", 32'(v_active), 32'(cur.v_act));
            check("h_total", 32'(h_total), 32'(cur.h_tot));
            check("v_total", 32'(v_total), 32'(cur.v_tot));
            check("frame_crc", 32'(frame_crc), 32'(cur.crc));
            check("frame_cnt", 32'(frame_cnt), 32'(cur.fcnt));
        end
    end

    initial begin
        fr_t f;
        logic [15:0] c;
        logic [11:0] words [6];
        int p0, ha, va, ht, vt, reps, gap;

        cur = '{default: 0};
        pins_idle();
        repeat (4) @(posedge pixclk);
        #1 resetn = 1;
        @(posedge pixclk); #1;
        check_all_zero("reset");

        // Pin the CRC model: "123456789" packed into 12-bit words gives the CCITT-FALSE check value.
        words = '{12'h313, 12'h233, 12'h343, 12'h536, 12'h373, 12'h839};
        c = 16'hFFFF;
        for (int i = 0; i < 6; i++) c = crc12(c, words[i]);
        check("crc_model_check_value", 32'(c), 32'h29B1);

        // Tiny timing, constant pixel 0x000.
        for (int i = 0; i < 3; i++) run_frame(mk(16, 8, 24, 12, 1, 0, 0));
        check("t1_pulses", 32'(pulses), 2);
        check("t1_frame_cnt", 32'(frame_cnt), 2);
        check("t1_h_active", 32'(h_active), 16);
        check("t1_v_active", 32'(v_active), 8);
        check("t1_h_total", 32'(h_total), 24);
        check("t1_v_total", 32'(v_total), 12);
        check("t1_not_locked_yet", 32'(locked), 0);
        run_frame(mk(16, 8, 24, 12, 1, 0, 0));
        check("t1_locked", 32'(locked), 1);

        // Gradient frames, one with a single altered pixel.
        for (int i = 0; i < 3; i++) begin
            f = mk(16, 8, 24, 12, int'($urandom_range(0, 2)), 1, 0);
            f.alt = (i == 1);
            run_frame(f);
        end

        // h_total disturbance while locked, then clear and relock.
        run_frame(mk(16, 8, 26, 12, 1, 2, 5));
        run_frame(mk(16, 8, 24, 12, 1, 2, 6));
        check("t3_err_timing", 32'(err_timing), 1);
        check("t3_unlocked", 32'(locked), 0);
        f = mk(16, 8, 24, 12, 1, 2, 7);
        f.clr = 1;
        run_frame(f);
        check("t3_err_cleared", 32'(err_timing), 0);
        run_frame(mk(16, 8, 24, 12, 2, 2, 8));
        run_frame(mk(16, 8, 24, 12, 0, 2, 9));
        check("t3_relocked", 32'(locked), 1);

        // One short line.
        f = mk(16, 8, 24, 12, 1, 2, 10);
        f.short_line = 3;
        run_frame(f);
        check("t4_err_line", 32'(err_line), 1);
        run_frame(mk(16, 8, 24, 12, 1, 2, 11));
        check("t4_h_active", 32'(h_active), 16);
        check("t4_locked", 32'(locked), 1);

        // HS and VS rising together.
        for (int i = 0; i < 2; i++) run_frame(mk(16, 8, 24, 12, 0, 2, 20 + i));
        check("t6_v_total", 32'(v_total), 12);
        check("t6_v_active", 32'(v_active), 8);

        // Reset mid-frame; capture resumes after two VS rises.
        f = mk(16, 8, 24, 12, 1, 2, 30);
        f.rst_line = 3;
        run_frame(f);
        p0 = pulses;
        run_frame(mk(16, 8, 24, 12, 1, 2, 31));
        check("t5_no_pulse_first_vs", 32'(pulses), 32'(p0));
        check("t5_frame_cnt_zero", 32'(frame_cnt), 0);
        run_frame(mk(16, 8, 24, 12, 1, 2, 32));
        check("t5_pulse_second_vs", 32'(pulses), 32'(p0 + 1));
        check("t5_frame_cnt_one", 32'(frame_cnt), 1);

        // Randomized geometry, content, VS phase, short lines and clears.
        for (int g = 0; g < 5; g++) begin
            ha = int'($urandom_range(4, 20));
            gap = int'($urandom_range(6, 10));
            ht = ha + gap;
            va = int'($urandom_range(2, 8));
            vt = va + int'($urandom_range(2, 4));
            reps = int'($urandom_range(1, 3));
            for (int r = 0; r < reps; r++) begin
                f = mk(ha, va, ht, vt, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), int'($urandom));
                if ($urandom_range(0, 3) == 0) f.short_line = int'($urandom_range(1, va - 1));
                if ($urandom_range(0, 3) == 0) f.clr = 1;
                f.alt = int'($urandom_range(0, 1));
                run_frame(f);
            end
        end

        run_tail();
        check("final_queue_empty", 32'(exp_q.size()), 0);
        check("final_pulse_count", 32'(pulses), 32'(pushed));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
